// File: rtl/sid_reg_sequencer_pkg.sv
// sid_reg_sequencer_pkg: shared command layout, FSM states and SID register constants.
package sid_reg_sequencer_pkg;
  localparam int CMD_W        = 16;
  localparam int CMD_WAIT_BIT = 15;
  localparam int VOICE_LSB    = 11;
  localparam int ADDR_LSB     = 8;
  localparam int DATA_LSB     = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  localparam logic [2:0] REG_FREQ = 3'd0;
  localparam logic [2:0] REG_PW   = 3'd2;
  localparam logic [2:0] REG_ATK  = 3'd4;
  localparam logic [2:0] REG_SUS  = 3'd5;
  localparam logic [2:0] REG_WAV  = 3'd6;

  localparam logic [7:0] WAV_GATE  = 8'h01;
  localparam logic [7:0] WAV_TRI   = 8'h10;
  localparam logic [7:0] WAV_SAW   = 8'h20;
  localparam logic [7:0] WAV_PULSE = 8'h40;
  localparam logic [7:0] WAV_NOISE = 8'h80;

  function automatic logic [CMD_W-1:0] mk_write(input logic [1:0] voice, input logic [2:0] addr,
                                                input logic [7:0] data);
    return {3'b000, voice, addr, data};
  endfunction

  function automatic logic [CMD_W-1:0] mk_wait(input logic [14:0] ticks);
    return {1'b1, ticks};
  endfunction
endpackage

// File: rtl/sid_reg_sequencer_fifo.sv
// sid_reg_sequencer_fifo: DEPTH x W single-clock show-ahead FIFO with flush and occupancy.
//  clk_i/rst_ni      clock, async active-low reset
//  flush_i           empties the FIFO; a same-cycle push or pop is ignored
//  push_i/wdata_i    write request (dropped while full)
//  pop_i             consume head word (ignored while empty)
//  rdata_o           head word, valid whenever !empty_o
//  full_o/empty_o    occupancy flags
//  level_o           number of stored words, 0..DEPTH
module sid_reg_sequencer_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_q];
  assign level_o = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/sid_reg_sequencer.sv
// sid_reg_sequencer: queues host WRITE/WAIT commands and replays them onto the SID register bus.
//  clk_i/rst_ni            clock, async active-low reset
//  cmd_valid_i/cmd_ready_o host push handshake (ready = FIFO not full)
//  cmd_data_i              [15]=0 WRITE {voice[12:11],addr[10:8],data[7:0]}; [15]=1 WAIT ticks[14:0]
//  flush_i                 drops queued commands and aborts a running WAIT
//  frame_tick_i            one-cycle pulse per SID frame, decrements WAIT
//  sid_addr_o/voice_o/data_o  held bus to the SID register file
//  sid_wr_o                one-cycle strobe per WRITE
//  busy_o                  FSM active or commands pending
//  level_o                 FIFO occupancy
module sid_reg_sequencer
  import sid_reg_sequencer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WAIT_W = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [CMD_W-1:0]       cmd_data_i,
  input  logic                   flush_i,
  input  logic                   frame_tick_i,
  output logic [2:0]             sid_addr_o,
  output logic [1:0]             sid_voice_o,
  output logic [7:0]             sid_data_o,
  output logic                   sid_wr_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);
  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [2:0]        addr_q;
  logic [1:0]        voice_q;
  logic [7:0]        data_q;
  logic              wr_q;
  logic [CMD_W-1:0]  head;
  logic              empty, full, pop, is_wait, wait_done;

  sid_reg_sequencer_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (cmd_valid_i),
    .pop_i   (pop),
    .wdata_i (cmd_data_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign is_wait   = head[CMD_WAIT_BIT];
  assign wait_done = cnt_q == '0 || (frame_tick_i && cnt_q == WAIT_W'(1));
  // Leaving WAIT takes the IDLE decision on the same edge, so a zero wait costs one cycle.
  assign pop = !flush_i && !empty &&
               (state_q == ST_IDLE || state_q == ST_HOLD || (state_q == ST_WAIT && wait_done));
  assign cmd_ready_o = !full;
  assign busy_o      = state_q != ST_IDLE || !empty;
  assign sid_addr_o  = addr_q;
  assign sid_voice_o = voice_q;
  assign sid_data_o  = data_q;
  assign sid_wr_o    = wr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      voice_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (pop) begin
        state_q <= is_wait ? ST_WAIT : ST_SETUP;
        cnt_q   <= is_wait ? head[WAIT_W-1:0] : '0;
        if (!is_wait) begin
          addr_q  <= head[ADDR_LSB +: 3];
          voice_q <= head[VOICE_LSB +: 2];
          data_q  <= head[DATA_LSB +: 8];
        end
      end else begin
        // SETUP/STROBE ignore flush so an issued write always gets exactly one strobe.
        case (state_q)
          ST_SETUP: begin
            state_q <= ST_STROBE;
            wr_q    <= 1'b1;
          end
          ST_STROBE: state_q <= ST_HOLD;
          ST_WAIT: begin
            if (flush_i || wait_done) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if (frame_tick_i) begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sid_reg_sequencer.sv
// tb_sid_reg_sequencer: scoreboard bench with directed timing cases and a randomized command stream.
module tb_sid_reg_sequencer;
  import sid_reg_sequencer_pkg::*;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, flush = 1'b0, frame_tick = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready, sid_wr, busy;
  logic [2:0]  sid_addr;
  logic [1:0]  sid_voice;
  logic [7:0]  sid_data;
  logic [3:0]  level;

  sid_reg_sequencer #(.DEPTH(DEPTH), .WAIT_W(15)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_data_i   (cmd_data),
    .flush_i      (flush),
    .frame_tick_i (frame_tick),
    .sid_addr_o   (sid_addr),
    .sid_voice_o  (sid_voice),
    .sid_data_o   (sid_data),
    .sid_wr_o     (sid_wr),
    .busy_o       (busy),
    .level_o      (level)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, cyc = 0, tick_mode = 0;
  logic [12:0] exp_q[$];
  int          strobe_edge[$];
  int          tick_edge[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ticks seen by the DUT at edge cyc+1.
  initial forever begin
    @(negedge clk);
    if (tick_mode != 0) begin
      frame_tick = tick_mode == 1 ? (cyc % 5 == 0) : ($urandom_range(3) == 0);
      if (frame_tick) tick_edge.push_back(cyc + 1);
    end
  end

  // Monitor: scoreboard on every strobe plus bus/handshake invariants.
  initial begin
    logic        prev_wr, chg_pend;
    logic [12:0] prev_bus, e;
    prev_wr = 1'b0; chg_pend = 1'b0; prev_bus = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr = 1'b0; chg_pend = 1'b0; prev_bus = '0;
      end else begin
        if (chg_pend) check("bus_change_without_strobe", sid_wr, 1);
        chg_pend = !sid_wr && {sid_voice, sid_addr, sid_data} != prev_bus;
        check("ready_eq_not_full", cmd_ready, level != 4'(DEPTH));
        if (sid_wr) begin
          strobe_edge.push_back(cyc);
          check("strobe_width", prev_wr, 0);
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got v%0d a%0d d%0h, none expected", sid_voice, sid_addr, sid_data);
          end else begin
            e = exp_q.pop_front();
            if ({sid_voice, sid_addr, sid_data} !== e) begin
              n_fail++;
              $display("FAIL strobe_fields: got %0h expected %0h", {sid_voice, sid_addr, sid_data}, e);
            end
          end
        end
        prev_wr = sid_wr;
        prev_bus = {sid_voice, sid_addr, sid_data};
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] c);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data = c;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("push_timeout", 1, 0);
    else if (!c[15]) exp_q.push_back(c[12:0]);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", busy || exp_q.size() != 0, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int e0, pop_edge, t3, k, x;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", sid_wr, 0);
    check("rst_bus", {sid_voice, sid_addr, sid_data}, 0);
    rst_n = 1'b1;
    idle(1);

    // Single write: strobe two edges after the accepting edge.
    strobe_edge.delete();
    push(16'h0A80);
    e0 = cyc;
    idle(6);
    check("t1_strobes", strobe_edge.size(), 1);
    check("t1_latency", strobe_edge[0], e0 + 2);
    check("t1_bus_held", {sid_voice, sid_addr, sid_data}, {2'd1, 3'd2, 8'h80});

    // Burst: one strobe every 3 cycles.
    strobe_edge.delete();
    for (int i = 0; i < 4; i++) push(mk_write(2'(i), REG_FREQ, 8'($urandom)));
    drain();
    check("t2_strobes", strobe_edge.size(), 4);
    for (int i = 1; i < 4; i++) check("t2_spacing", strobe_edge[i] - strobe_edge[i-1], 3);

    // Zero wait costs exactly one extra cycle.
    strobe_edge.delete();
    push(mk_write(2'd2, REG_ATK, 8'h5A));
    push(16'h8000);
    push(mk_write(2'd2, REG_SUS, 8'hA5));
    drain();
    check("t4_strobes", strobe_edge.size(), 2);
    check("t4_spacing", strobe_edge[1] - strobe_edge[0], 4);

    // Timed gate with a tick every 5 cycles.
    strobe_edge.delete();
    tick_edge.delete();
    tick_mode = 1;
    push(mk_write(2'd0, REG_WAV, WAV_SAW | WAV_GATE));
    push(16'h8003);
    push(mk_write(2'd0, REG_WAV, WAV_SAW));
    drain();
    tick_mode = 0;
    frame_tick = 1'b0;
    check("t3_strobes", strobe_edge.size(), 2);
    pop_edge = strobe_edge[0] + 2;
    t3 = -1;
    k = 0;
    foreach (tick_edge[i]) if (tick_edge[i] > pop_edge && k < 3) begin
      k++;
      if (k == 3) t3 = tick_edge[i];
    end
    check("t3_gate_timing", strobe_edge[1], t3 + 1);
    check("t3_bus", sid_data, 8'h20);

    // A tick on the WAIT pop edge must not be counted.
    idle(2);
    strobe_edge.delete();
    push(mk_write(2'd1, REG_PW, 8'h11));
    e0 = cyc;
    push(16'h8001);
    push(mk_write(2'd1, REG_PW, 8'h22));
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    idle(5);
    frame_tick = 1'b1;
    x = cyc + 1;
    @(negedge clk);
    frame_tick = 1'b0;
    idle(6);
    check("t3b_strobes", strobe_edge.size(), 2);
    check("t3b_first", strobe_edge[0], e0 + 2);
    check("t3b_second", strobe_edge[1], x + 1);

    // Flush mid-WAIT with three queued writes.
    strobe_edge.delete();
    push(16'h8064);
    for (int i = 0; i < 3; i++) push(mk_write(2'(i), REG_SUS, 8'(i + 1)));
    idle(2);
    check("t5_level_before", level, 3);
    check("t5_busy_before", busy, 1);
    do_flush();
    exp_q.delete();
    check("t5_level_after", level, 0);
    check("t5_busy_after", busy, 0);
    idle(20);
    check("t5_no_strobe", strobe_edge.size(), 0);

    // Fill to DEPTH behind a long WAIT, push while full, then flush with a same-cycle push.
    push(16'h8064);
    for (int i = 0; i < DEPTH; i++) push(mk_write(2'd3, 3'(i), 8'(i)));
    idle(2);
    check("full_ready", cmd_ready, 0);
    check("full_level", level, DEPTH);
    cmd_valid = 1'b1;
    cmd_data = mk_write(2'd0, REG_FREQ, 8'hEE);
    idle(1);
    cmd_valid = 1'b0;
    check("full_push_refused", level, DEPTH);
    do_flush();
    exp_q.delete();
    check("full_flush_level", level, 0);
    cmd_valid = 1'b1;
    flush = 1'b1;
    idle(1);
    cmd_valid = 1'b0;
    flush = 1'b0;
    check("flush_drops_push", level, 0);
    idle(10);
    check("flush_no_strobe", strobe_edge.size(), 0);

    // Flush across SETUP and STROBE: the write still strobes once.
    push(mk_write(2'd1, REG_WAV, WAV_PULSE | WAV_GATE));
    e0 = cyc;
    idle(1);
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = mk_write(2'd2, REG_FREQ, 8'h33);
    idle(2);
    flush = 1'b0;
    cmd_valid = 1'b0;
    idle(10);
    check("flush_strobe_count", strobe_edge.size(), 1);
    check("flush_strobe_edge", strobe_edge[0], e0 + 2);
    check("flush_scoreboard_empty", exp_q.size(), 0);
    check("flush_level", level, 0);

    // Async reset during STROBE.
    push(mk_write(2'd0, REG_ATK, 8'h9C));
    idle(2);
    check("rst_mid_wr_high", sid_wr, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_wr_drop", sid_wr, 0);
    check("rst_mid_bus", {sid_voice, sid_addr, sid_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_level", level, 0);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    idle(2);

    // Randomized stream against the scoreboard.
    tick_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 75) push(mk_write(2'($urandom), 3'($urandom), 8'($urandom)));
      else push(mk_wait(15'($urandom_range(3))));
      if ($urandom_range(3) == 0) idle($urandom_range(4));
    end
    drain();
    tick_mode = 0;
    frame_tick = 1'b0;
    check("rand_scoreboard_empty", exp_q.size(), 0);
    check("rand_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
